// File: rtl/game_flow_controller_pkg.sv
// game_pkg: shared definitions for the FlappyBox game flow controller.
//   - game_state_e : TITLE / PLAY / DYING / OVER state encodings
//   - FCNT_W       : width of every frame counter
//   - DEF_*_FRAMES : default frame constants
//   - frames_legal : legality check for frame-count parameters
package game_pkg;

  localparam int FCNT_W = 8;

  typedef enum logic [1:0] {
    GS_TITLE = 2'd0,
    GS_PLAY  = 2'd1,
    GS_DYING = 2'd2,
    GS_OVER  = 2'd3
  } game_state_e;

  localparam int DEF_DEATH_FRAMES   = 30;
  localparam int DEF_LOCKOUT_FRAMES = 60;
  localparam int DEF_BLINK_FRAMES   = 32;

  // A frame count must be at least 1 and fit in an FCNT_W-bit counter.
  function automatic bit frames_legal(input int v);
    return (v >= 1) && (v <= (2 ** FCNT_W) - 1);
  endfunction

endpackage

// File: rtl/game_flow_controller_frame_counter.sv
// frame_counter: per-frame event counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : counting enabled
//   clr_i         : synchronous clear to 0 (wins over counting)
//   tick_i        : one-cycle frame pulse
//   sat_i         : 1 = hold at term_i, 0 = wrap to 0 after term_i
//   term_i        : terminal count value
//   at_term_o     : count currently equals term_i
//   wrap_o        : tick that wraps the counter (only when sat_i=0)
module frame_counter
  import game_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              tick_i,
  input  logic              sat_i,
  input  logic [FCNT_W-1:0] term_i,
  output logic              at_term_o,
  output logic              wrap_o
);

  logic [FCNT_W-1:0] cnt_q;

  assign at_term_o = (cnt_q == term_i);
  assign wrap_o    = en_i & tick_i & at_term_o & ~sat_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && tick_i) begin
      if (at_term_o) begin
        if (!sat_i) cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + FCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: TITLE / PLAY / DYING / OVER sequencer for FlappyBox.
//   clk          : pixel-domain clock
//   reset        : asynchronous active-low reset
//   frame_tick   : one pulse per video frame
//   btn          : debounced jump button level
//   collision    : bird hits pipe or ground
//   gameover_on  : per-pixel hit from the game-over overlay unit
//   play_en      : high in PLAY
//   freeze       : high in DYING and OVER
//   title_en     : high in TITLE
//   gameover_pix : gameover_on gated by OVER state and blink phase
//   game_restart : one-cycle restart pulse for bird/pipe/score logic
//   state_o      : current state encoding
module game_flow_controller
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES   = DEF_DEATH_FRAMES,
  parameter int LOCKOUT_FRAMES = DEF_LOCKOUT_FRAMES,
  parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn,
  input  logic       collision,
  input  logic       gameover_on,
  output logic       play_en,
  output logic       freeze,
  output logic       title_en,
  output logic       gameover_pix,
  output logic       game_restart,
  output logic [1:0] state_o
);

  if (!frames_legal(DEATH_FRAMES)) begin : g_bad_death
    $error("DEATH_FRAMES must be within 1..255");
  end
  if (!frames_legal(LOCKOUT_FRAMES)) begin : g_bad_lockout
    $error("LOCKOUT_FRAMES must be within 1..255");
  end
  if (!frames_legal(BLINK_FRAMES)) begin : g_bad_blink
    $error("BLINK_FRAMES must be within 1..255");
  end

  localparam logic [FCNT_W-1:0] DEATH_TERM   = FCNT_W'(DEATH_FRAMES - 1);
  localparam logic [FCNT_W-1:0] LOCKOUT_TERM = FCNT_W'(LOCKOUT_FRAMES);
  localparam logic [FCNT_W-1:0] BLINK_TERM   = FCNT_W'(BLINK_FRAMES - 1);

  game_state_e state_q;
  logic        btn_q;
  logic        restart_q;
  logic        blink_vis_q;

  logic              btn_rise;
  logic              in_over;
  logic              in_dying;
  logic              restart_go;
  logic              death_done;
  logic [FCNT_W-1:0] fc_term;
  logic              fc_en;
  logic              fc_clr;
  logic              fc_at_term;
  logic              fc_wrap;
  logic              bc_at_term;
  logic              blink_wrap;

  assign btn_rise = btn & ~btn_q;
  assign in_over  = (state_q == GS_OVER);
  assign in_dying = (state_q == GS_DYING);

  // One counter serves both the death delay (wrapping at DEATH_FRAMES-1, so it
  // is already 0 on the first OVER cycle) and the lockout (saturating).
  assign fc_term    = in_dying ? DEATH_TERM : LOCKOUT_TERM;
  assign fc_en      = in_dying | in_over;
  assign fc_clr     = ~fc_en | restart_go;
  assign death_done = in_dying & fc_wrap;

  // Armed is sampled before this cycle's tick, so a rise coinciding with the
  // arming tick is still discarded.
  assign restart_go = in_over & fc_at_term & btn_rise;

  frame_counter u_life_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .en_i      (fc_en),
    .clr_i     (fc_clr),
    .tick_i    (frame_tick),
    .sat_i     (in_over),
    .term_i    (fc_term),
    .at_term_o (fc_at_term),
    .wrap_o    (fc_wrap)
  );

  frame_counter u_blink_cnt (
    .clk_i     (clk),
    .rst_ni    (reset),
    .en_i      (in_over),
    .clr_i     (~in_over | restart_go),
    .tick_i    (frame_tick),
    .sat_i     (1'b0),
    .term_i    (BLINK_TERM),
    .at_term_o (bc_at_term),
    .wrap_o    (blink_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= GS_TITLE;
      btn_q       <= 1'b0;
      restart_q   <= 1'b0;
      blink_vis_q <= 1'b1;
    end else begin
      btn_q     <= btn;
      restart_q <= 1'b0;
      unique case (state_q)
        GS_TITLE: begin
          if (btn_rise) begin
            state_q   <= GS_PLAY;
            restart_q <= 1'b1;
          end
        end
        GS_PLAY: begin
          if (collision) state_q <= GS_DYING;
        end
        GS_DYING: begin
          if (death_done) begin
            state_q     <= GS_OVER;
            blink_vis_q <= 1'b1;
          end
        end
        GS_OVER: begin
          if (restart_go) begin
            state_q     <= GS_PLAY;
            restart_q   <= 1'b1;
            blink_vis_q <= 1'b1;
          end else if (blink_wrap) begin
            blink_vis_q <= ~blink_vis_q;
          end
        end
      endcase
    end
  end

  assign play_en      = (state_q == GS_PLAY);
  assign freeze       = in_dying | in_over;
  assign title_en     = (state_q == GS_TITLE);
  assign gameover_pix = gameover_on & in_over & blink_vis_q;
  assign game_restart = restart_q;
  assign state_o      = state_q;

  // The blink counter only needs its wrap output.
  logic unused_bc;
  assign unused_bc = bc_at_term;

endmodule
